ctrl_secuenciador: RTL and testbench



---
 rtl/ctrl_secuenciador_pkg.sv | 37 +++
 rtl/ctrl_secuenciador_decodificador.sv | 22 ++
 rtl/ctrl_secuenciador.sv | 92 +++++++++
 tb/tb_ctrl_secuenciador.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_secuenciador_pkg.sv
// ctrl_secuenciador_pkg: opcodes, ALU selects, FSM states and control word shared by the sequencer.
package ctrl_secuenciador_pkg;
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LIT   = 4'h1;
    localparam logic [3:0] OP_IN    = 4'h2;
    localparam logic [3:0] OP_OUT   = 4'h3;
    localparam logic [3:0] OP_ADDI  = 4'h4;
    localparam logic [3:0] OP_SUBI  = 4'h5;
    localparam logic [3:0] OP_NANDI = 4'h6;
    localparam logic [3:0] OP_CMPI  = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_JC    = 4'h9;
    localparam logic [3:0] OP_JNC   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_JNZ   = 4'hC;

    localparam logic [2:0] SEL_PASSA = 3'b000;
    localparam logic [2:0] SEL_SUB   = 3'b001;
    localparam logic [2:0] SEL_PASSB = 3'b010;
    localparam logic [2:0] SEL_ADD   = 3'b011;
    localparam logic [2:0] SEL_NAND  = 3'b100;

    typedef enum logic [1:0] {FETCH, EXEC, JUMP} state_t;

    typedef struct packed {
        logic [2:0] sel;
        logic       en_acu;
        logic       oe_oprnd;
        logic       oe_in;
        logic       en_out;
        logic       upd_flags;
    } ctrl_t;

    function automatic logic is_jump(input logic [3:0] op);
        return (op >= OP_JMP) && (op <= OP_JNZ);
    endfunction
endpackage

// File: rtl/ctrl_secuenciador_decodificador.sv
// ctrl_decodificador: combinational map from opcode to the EXEC-cycle control word.
module ctrl_decodificador
    import ctrl_secuenciador_pkg::*;
(
    input  logic [3:0] opcode_i,
    output ctrl_t      ctrl_o
);
    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OP_LIT:   ctrl_o = '{sel: SEL_PASSB, en_acu: 1'b1, oe_oprnd: 1'b1, oe_in: 1'b0, en_out: 1'b0, upd_flags: 1'b1};
            OP_IN:    ctrl_o = '{sel: SEL_PASSB, en_acu: 1'b1, oe_oprnd: 1'b0, oe_in: 1'b1, en_out: 1'b0, upd_flags: 1'b1};
            OP_OUT:   ctrl_o = '{sel: SEL_PASSA, en_acu: 1'b0, oe_oprnd: 1'b0, oe_in: 1'b0, en_out: 1'b1, upd_flags: 1'b0};
            OP_ADDI:  ctrl_o = '{sel: SEL_ADD,   en_acu: 1'b1, oe_oprnd: 1'b1, oe_in: 1'b0, en_out: 1'b0, upd_flags: 1'b1};
            OP_SUBI:  ctrl_o = '{sel: SEL_SUB,   en_acu: 1'b1, oe_oprnd: 1'b1, oe_in: 1'b0, en_out: 1'b0, upd_flags: 1'b1};
            OP_NANDI: ctrl_o = '{sel: SEL_NAND,  en_acu: 1'b1, oe_oprnd: 1'b1, oe_in: 1'b0, en_out: 1'b0, upd_flags: 1'b1};
            // CMPI runs the subtract only for its flags
            OP_CMPI:  ctrl_o = '{sel: SEL_SUB,   en_acu: 1'b0, oe_oprnd: 1'b1, oe_in: 1'b0, en_out: 1'b0, upd_flags: 1'b1};
            default:  ctrl_o = '0;
        endcase
    end
endmodule

// File: rtl/ctrl_secuenciador.sv
// ctrl_secuenciador: fetch/decode sequencer driving the ALU/accumulator controls.
// Owns the PC, instruction register, Carry/Zero flags and the FETCH/EXEC/JUMP FSM.
module ctrl_secuenciador
    import ctrl_secuenciador_pkg::*;
#(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk4,
    input  logic            reset4,
    input  logic [7:0]      rom_data,
    input  logic            alu_carry,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc_addr,
    output logic [3:0]      oprnd,
    output logic [2:0]      alu_select,
    output logic            en_acu,
    output logic            oe_oprnd,
    output logic            oe_in,
    output logic            en_out,
    output logic            flag_c,
    output logic            flag_z,
    output logic            phase
);
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      instr_q, instr_d;
    logic            fc_q, fc_d, fz_q, fz_d;
    ctrl_t           dec, ctrl;
    logic [3:0]      op;
    logic            taken;

    assign op = instr_q[7:4];

    ctrl_decodificador u_dec (
        .opcode_i(op),
        .ctrl_o  (dec)
    );

    assign taken = (op == OP_JMP) || (op == OP_JC && fc_q) || (op == OP_JNC && !fc_q)
                || (op == OP_JZ && fz_q) || (op == OP_JNZ && !fz_q);

    always_ff @(posedge clk4 or posedge reset4) begin
        if (reset4) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 8'h00;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fc_q    <= fc_d;
            fz_q    <= fz_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        pc_d    = pc_q;
        instr_d = instr_q;
        fc_d    = fc_q;
        fz_d    = fz_q;
        case (state_q)
            FETCH: begin
                instr_d = rom_data;
                pc_d    = pc_q + PC_W'(1);
                state_d = is_jump(rom_data[7:4]) ? JUMP : EXEC;
            end
            EXEC: begin
                fc_d = dec.upd_flags ? alu_carry : fc_q;
                fz_d = dec.upd_flags ? alu_zero : fz_q;
            end
            // rom_data now carries the low target byte
            JUMP: pc_d = taken ? PC_W'({instr_q[3:0], rom_data}) : pc_q + PC_W'(1);
            default: state_d = FETCH;
        endcase
    end

    assign ctrl       = (state_q == EXEC) ? dec : '0;
    assign pc_addr    = pc_q;
    assign oprnd      = instr_q[3:0];
    assign alu_select = ctrl.sel;
    assign en_acu     = ctrl.en_acu;
    assign oe_oprnd   = ctrl.oe_oprnd;
    assign oe_in      = ctrl.oe_in;
    assign en_out     = ctrl.en_out;
    assign flag_c     = fc_q;
    assign flag_z     = fz_q;
    assign phase      = (state_q != FETCH);
endmodule

// File: tb/tb_ctrl_secuenciador.sv
// tb_ctrl_secuenciador: ROM + ALU/accumulator model around the sequencer; expected
// per-cycle outputs are queued and compared as the DUT steps through each program.
module tb_ctrl_secuenciador;
    logic        clk4, reset4;
    logic [7:0]  rom [0:4095];
    logic [3:0]  in_port, acc;
    logic [11:0] pc_addr, pc2;
    logic [3:0]  oprnd, oprnd2;
    logic [2:0]  alu_select, sel2;
    logic        en_acu, oe_oprnd, oe_in, en_out, flag_c, flag_z, phase;
    logic        ea2, oo2, oi2, eo2, fc2, fz2, ph2;
    logic        alu_carry, alu_zero;
    logic [3:0]  b_bus;
    logic [4:0]  r5;

    typedef struct {
        string       nm;
        logic [21:0] v;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  sel;
        logic [3:0]  ctl;
        logic [1:0]  fl;
        logic [11:0] pc3;
    } dec_t;

    exp_t q[$];
    dec_t tab[16];
    int   tests, errs;

    ctrl_secuenciador u0 (
        .clk4(clk4), .reset4(reset4), .rom_data(rom[pc_addr]), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .pc_addr(pc_addr), .oprnd(oprnd), .alu_select(alu_select), .en_acu(en_acu), .oe_oprnd(oe_oprnd),
        .oe_in(oe_in), .en_out(en_out), .flag_c(flag_c), .flag_z(flag_z), .phase(phase)
    );

    ctrl_secuenciador #(.RESET_PC(12'hFFE)) u1 (
        .clk4(clk4), .reset4(reset4), .rom_data(rom[pc2]), .alu_carry(1'b0), .alu_zero(1'b0),
        .pc_addr(pc2), .oprnd(oprnd2), .alu_select(sel2), .en_acu(ea2), .oe_oprnd(oo2),
        .oe_in(oi2), .en_out(eo2), .flag_c(fc2), .flag_z(fz2), .phase(ph2)
    );

    // ALU: A = accumulator, B = operand nibble or input port; carry on SUB is the borrow
    always_comb begin
        b_bus = oe_oprnd ? oprnd : (oe_in ? in_port : 4'h0);
        case (alu_select)
            3'b001:  r5 = {1'b0, acc} - {1'b0, b_bus};
            3'b010:  r5 = {1'b0, b_bus};
            3'b011:  r5 = {1'b0, acc} + {1'b0, b_bus};
            3'b100:  r5 = {1'b0, ~(acc & b_bus)};
            default: r5 = {1'b0, acc};
        endcase
        alu_carry = r5[4];
        alu_zero  = (r5[3:0] == 4'h0);
    end

    always @(posedge clk4 or posedge reset4)
        if (reset4) acc <= 4'h0;
        else if (en_acu) acc <= r5[3:0];

    initial clk4 = 1'b0;
    always #5 clk4 = ~clk4;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic exp_t mk(string nm, logic [11:0] pc, logic [2:0] sel, logic [3:0] ctl,
                                logic [1:0] fl, logic ph);
        exp_t e;
        e.nm = nm;
        e.v  = {pc, sel, ctl, fl, ph};
        return e;
    endfunction

    task automatic check(exp_t e);
        logic [21:0] act;
        act = {pc_addr, alu_select, en_acu, oe_oprnd, oe_in, en_out, flag_c, flag_z, phase};
        tests++;
        if (act !== e.v) begin
            errs++;
            $display("FAIL %s: got {pc,sel,ea,oo,oi,eo,c,z,ph}=%h required %h", e.nm, act, e.v);
        end
    endtask

    task automatic check_acc(string nm, logic [3:0] want);
        tests++;
        if (acc !== want) begin
            errs++;
            $display("FAIL %s: got acc=%h required %h", nm, acc, want);
        end
    endtask

    task automatic check_u1(string nm, logic [11:0] pc, logic ph);
        tests++;
        if ({pc2, ph2} !== {pc, ph}) begin
            errs++;
            $display("FAIL %s: got pc=%h phase=%b required pc=%h phase=%b", nm, pc2, ph2, pc, ph);
        end
    endtask

    task automatic run_q();
        while (q.size() > 0) begin
            check(q.pop_front());
            @(negedge clk4);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        reset4 = 1'b1;
        repeat (2) @(negedge clk4);
        reset4 = 1'b0;
        #1;
    endtask

    initial begin
        tests = 0;
        errs = 0;
        reset4 = 1'b1;
        in_port = 4'h0;
        clear_rom();
        //            op     sel     ea/oo/oi/eo  {c,z}  pc after cycle 2
        tab[0]  = '{4'h0, 3'b000, 4'b0000, 2'b00, 12'h001};
        tab[1]  = '{4'h1, 3'b010, 4'b1100, 2'b00, 12'h001};
        tab[2]  = '{4'h2, 3'b010, 4'b1010, 2'b01, 12'h001};
        tab[3]  = '{4'h3, 3'b000, 4'b0001, 2'b00, 12'h001};
        tab[4]  = '{4'h4, 3'b011, 4'b1100, 2'b00, 12'h001};
        tab[5]  = '{4'h5, 3'b001, 4'b1100, 2'b10, 12'h001};
        tab[6]  = '{4'h6, 3'b100, 4'b1100, 2'b00, 12'h001};
        tab[7]  = '{4'h7, 3'b001, 4'b0100, 2'b10, 12'h001};
        tab[8]  = '{4'h8, 3'b000, 4'b0000, 2'b00, 12'h540};
        tab[9]  = '{4'h9, 3'b000, 4'b0000, 2'b00, 12'h002};
        tab[10] = '{4'hA, 3'b000, 4'b0000, 2'b00, 12'h540};
        tab[11] = '{4'hB, 3'b000, 4'b0000, 2'b00, 12'h002};
        tab[12] = '{4'hC, 3'b000, 4'b0000, 2'b00, 12'h540};
        tab[13] = '{4'hD, 3'b000, 4'b0000, 2'b00, 12'h001};
        tab[14] = '{4'hE, 3'b000, 4'b0000, 2'b00, 12'h001};
        tab[15] = '{4'hF, 3'b000, 4'b0000, 2'b00, 12'h001};

        // every opcode with operand 5, low byte 0x40, acc = 0, in_port = 0
        for (int i = 0; i < 16; i++) begin
            clear_rom();
            rom[0] = {tab[i].op, 4'h5};
            rom[1] = 8'h40;
            do_reset();
            q.push_back(mk($sformatf("dec_fetch_op%0h", tab[i].op), 12'h000, 3'b000, 4'b0000, 2'b00, 1'b0));
            q.push_back(mk($sformatf("dec_exec_op%0h", tab[i].op), 12'h001, tab[i].sel, tab[i].ctl, 2'b00, 1'b1));
            q.push_back(mk($sformatf("dec_next_op%0h", tab[i].op), tab[i].pc3, 3'b000, 4'b0000, tab[i].fl, 1'b0));
            run_q();
        end

        // LIT 5; ADDI C -> acc 1 with carry
        clear_rom();
        rom[0] = 8'h15; rom[1] = 8'h4C;
        do_reset();
        q.push_back(mk("add_c1", 12'h000, 3'b000, 4'b0000, 2'b00, 1'b0));
        q.push_back(mk("add_c2", 12'h001, 3'b010, 4'b1100, 2'b00, 1'b1));
        q.push_back(mk("add_c3", 12'h001, 3'b000, 4'b0000, 2'b00, 1'b0));
        q.push_back(mk("add_c4", 12'h002, 3'b011, 4'b1100, 2'b00, 1'b1));
        q.push_back(mk("add_c5", 12'h002, 3'b000, 4'b0000, 2'b10, 1'b0));
        q.push_back(mk("add_c6", 12'h003, 3'b000, 4'b0000, 2'b10, 1'b1));
        run_q();
        check_acc("add_acc", 4'h1);

        // LIT 3; CMPI 3; JZ 0x120 taken
        clear_rom();
        rom[0] = 8'h13; rom[1] = 8'h73; rom[2] = 8'hB1; rom[3] = 8'h20;
        do_reset();
        q.push_back(mk("jz_c1", 12'h000, 3'b000, 4'b0000, 2'b00, 1'b0));
        q.push_back(mk("jz_c2", 12'h001, 3'b010, 4'b1100, 2'b00, 1'b1));
        q.push_back(mk("jz_c3", 12'h001, 3'b000, 4'b0000, 2'b00, 1'b0));
        q.push_back(mk("jz_c4", 12'h002, 3'b001, 4'b0100, 2'b00, 1'b1));
        q.push_back(mk("jz_c5", 12'h002, 3'b000, 4'b0000, 2'b01, 1'b0));
        q.push_back(mk("jz_c6", 12'h003, 3'b000, 4'b0000, 2'b01, 1'b1));
        q.push_back(mk("jz_c7", 12'h120, 3'b000, 4'b0000, 2'b01, 1'b0));
        q.push_back(mk("jz_c8", 12'h121, 3'b000, 4'b0000, 2'b01, 1'b1));
        run_q();
        check_acc("jz_acc", 4'h3);

        // CMPI 4 -> JZ not taken, low byte skipped, LIT at 4 executes
        clear_rom();
        rom[0] = 8'h13; rom[1] = 8'h74; rom[2] = 8'hB1; rom[3] = 8'h20; rom[4] = 8'h15;
        do_reset();
        q.push_back(mk("nz_c1", 12'h000, 3'b000, 4'b0000, 2'b00, 1'b0));
        q.push_back(mk("nz_c2", 12'h001, 3'b010, 4'b1100, 2'b00, 1'b1));
        q.push_back(mk("nz_c3", 12'h001, 3'b000, 4'b0000, 2'b00, 1'b0));
        q.push_back(mk("nz_c4", 12'h002, 3'b001, 4'b0100, 2'b00, 1'b1));
        q.push_back(mk("nz_c5", 12'h002, 3'b000, 4'b0000, 2'b10, 1'b0));
        q.push_back(mk("nz_c6", 12'h003, 3'b000, 4'b0000, 2'b10, 1'b1));
        q.push_back(mk("nz_c7", 12'h004, 3'b000, 4'b0000, 2'b10, 1'b0));
        q.push_back(mk("nz_c8", 12'h005, 3'b010, 4'b1100, 2'b10, 1'b1));
        run_q();

        // IN with port = 9, then OUT
        clear_rom();
        rom[0] = 8'h20; rom[1] = 8'h30;
        in_port = 4'h9;
        do_reset();
        q.push_back(mk("io_c1", 12'h000, 3'b000, 4'b0000, 2'b00, 1'b0));
        q.push_back(mk("io_c2", 12'h001, 3'b010, 4'b1010, 2'b00, 1'b1));
        q.push_back(mk("io_c3", 12'h001, 3'b000, 4'b0000, 2'b00, 1'b0));
        q.push_back(mk("io_c4", 12'h002, 3'b000, 4'b0001, 2'b00, 1'b1));
        q.push_back(mk("io_c5", 12'h002, 3'b000, 4'b0000, 2'b00, 1'b0));
        run_q();
        check_acc("io_acc", 4'h9);
        in_port = 4'h0;

        // async reset in the middle of ADDI after LIT 0 set Zero
        clear_rom();
        rom[0] = 8'h10; rom[1] = 8'h4C;
        do_reset();
        q.push_back(mk("rst_c1", 12'h000, 3'b000, 4'b0000, 2'b00, 1'b0));
        q.push_back(mk("rst_c2", 12'h001, 3'b010, 4'b1100, 2'b00, 1'b1));
        q.push_back(mk("rst_c3", 12'h001, 3'b000, 4'b0000, 2'b01, 1'b0));
        run_q();
        check(mk("rst_c4", 12'h002, 3'b011, 4'b1100, 2'b01, 1'b1));
        #2 reset4 = 1'b1;
        #1 check(mk("rst_async", 12'h000, 3'b000, 4'b0000, 2'b00, 1'b0));
        @(posedge clk4);
        #1 check(mk("rst_edge", 12'h000, 3'b000, 4'b0000, 2'b00, 1'b0));
        @(negedge clk4);
        reset4 = 1'b0;

        // PC wrap with RESET_PC = FFE: NOPs
        clear_rom();
        do_reset();
        check_u1("wrap_a1", 12'hFFE, 1'b0); @(negedge clk4); #1;
        check_u1("wrap_a2", 12'hFFF, 1'b1); @(negedge clk4); #1;
        check_u1("wrap_a3", 12'hFFF, 1'b0); @(negedge clk4); #1;
        check_u1("wrap_a4", 12'h000, 1'b1);

        // JMP fetched at FFF takes its low byte from 000
        clear_rom();
        rom[12'hFFF] = 8'h85; rom[12'h000] = 8'h34;
        do_reset();
        check_u1("wrap_j1", 12'hFFE, 1'b0); @(negedge clk4); #1;
        check_u1("wrap_j2", 12'hFFF, 1'b1); @(negedge clk4); #1;
        check_u1("wrap_j3", 12'hFFF, 1'b0); @(negedge clk4); #1;
        check_u1("wrap_j4", 12'h000, 1'b1); @(negedge clk4); #1;
        check_u1("wrap_j5", 12'h534, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
